// File: rtl/micro_sequencer.sv
// Fetch/decode/execute controller for the 4-bit microcode processor.
// Fetches over a req/ack handshake, times the ROM execute window, tracks pc and retired count.
module micro_sequencer #(
  parameter int          PC_W    = 4,
  parameter int          ALU_CYC = 2,
  parameter logic [7:0]  HALT_OP = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  output logic            pm_req,
  output logic [PC_W-1:0] pm_addr,
  input  logic            pm_ack,
  input  logic [7:0]      pm_data,
  output logic [7:0]      ir,
  output logic [1:0]      rom_en,
  output logic            ld_strobe,
  output logic            busy,
  output logic            halt,
  output logic [7:0]      icount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] ALU_LEN = 3'(ALU_CYC);
  localparam logic [2:0] IMM_LEN = 3'd1;

  state_t            state_r;
  state_t            state_s;
  logic [PC_W-1:0]   pc_r;
  logic [7:0]        ir_r;
  logic [7:0]        icount_r;
  logic [2:0]        cnt_r;
  logic              exec_last_s;
  logic              retire_s;

  // Down-counter reaching 1 marks the final EXEC cycle (load commit).
  always_comb begin
    exec_last_s = 1'b0;
    retire_s    = 1'b0;
    if ((state_r == S_EXEC) && (cnt_r == 3'd1)) begin
      exec_last_s = 1'b1;
    end else begin
      exec_last_s = 1'b0;
    end
    if (exec_last_s) begin
      retire_s = 1'b1;
    end else if ((state_r == S_DECODE) && (ir_r != HALT_OP) && (ir_r == 8'h00)) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
  end

  // Next-state logic; stop is honoured only at instruction boundaries.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_FETCH: begin
        if (pm_ack) state_s = S_DECODE;
        else        state_s = S_FETCH;
      end
      S_DECODE: begin
        if (ir_r == HALT_OP)    state_s = S_HALT;
        else if (ir_r == 8'h00) state_s = stop ? S_IDLE : S_FETCH;
        else                    state_s = S_EXEC;
      end
      S_EXEC: begin
        if (exec_last_s) state_s = stop ? S_IDLE : S_FETCH;
        else             state_s = S_EXEC;
      end
      S_HALT:  state_s = S_HALT;
      default: state_s = S_IDLE;
    endcase
  end

  // State, program counter, instruction register, EXEC counter and retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      pc_r     <= '0;
      ir_r     <= 8'h00;
      icount_r <= 8'h00;
      cnt_r    <= 3'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == S_FETCH) && pm_ack) begin
        ir_r <= pm_data;
        pc_r <= pc_r + PC_W'(1);
      end
      if ((state_r == S_DECODE) && (state_s == S_EXEC)) begin
        cnt_r <= ir_r[7] ? IMM_LEN : ALU_LEN;
      end else if (state_r == S_EXEC) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if (retire_s) begin
        icount_r <= icount_r + 8'd1;
      end
    end
  end

  // Outputs decoded purely from registered state so the ROM bus is released outside EXEC.
  always_comb begin
    pm_req    = 1'b0;
    rom_en    = 2'b00;
    ld_strobe = 1'b0;
    busy      = 1'b0;
    halt      = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_FETCH: begin
        pm_req = 1'b1;
        busy   = 1'b1;
      end
      S_DECODE: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        busy      = 1'b1;
        rom_en    = ir_r[7] ? 2'b10 : 2'b01;
        ld_strobe = exec_last_s;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pm_addr = pc_r;
  assign ir      = ir_r;
  assign icount  = icount_r;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: inputs change and outputs are checked on the falling edge.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, pm_ack, pm_req;
  logic [3:0] pm_addr;
  logic [7:0] pm_data, ir, icount;
  logic [1:0] rom_en;
  logic       ld_strobe, busy, halt;
  logic       ack_en;
  logic [7:0] mem [16];
  int         vectors = 0;
  int         errors  = 0;

  always #5 clk = ~clk;

  assign pm_ack  = ack_en;
  assign pm_data = mem[pm_addr];

  micro_sequencer #(.PC_W(4), .ALU_CYC(2), .HALT_OP(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pm_req(pm_req), .pm_addr(pm_addr), .pm_ack(pm_ack), .pm_data(pm_data),
    .ir(ir), .rom_en(rom_en), .ld_strobe(ld_strobe), .busy(busy),
    .halt(halt), .icount(icount)
  );

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stop = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    do_reset();
    vectors++; if (pm_req !== 1'b0) begin errors++; $display("FAIL rst_pm_req got=%b exp=0", pm_req); end
    vectors++; if (rom_en !== 2'b00) begin errors++; $display("FAIL rst_rom_en got=%b exp=00", rom_en); end
    vectors++; if (ld_strobe !== 1'b0) begin errors++; $display("FAIL rst_ld got=%b exp=0", ld_strobe); end
    vectors++; if (busy !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL rst_busy_halt got=%b%b exp=00", busy, halt); end
    vectors++; if (pm_addr !== 4'd0 || ir !== 8'h00 || icount !== 8'h00) begin
      errors++; $display("FAIL rst_regs pc=%0d ir=%h icount=%0d exp 0/00/0", pm_addr, ir, icount); end
  endtask

  task automatic test_imm();
    clear_mem(); mem[0] = 8'hA5;
    do_reset(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++; if (pm_req !== 1'b1 || pm_addr !== 4'd0) begin errors++; $display("FAIL imm_fetch req=%b addr=%0d exp 1/0", pm_req, pm_addr); end
    @(negedge clk);
    vectors++; if (rom_en !== 2'b00 || ir !== 8'hA5 || pm_addr !== 4'd1) begin
      errors++; $display("FAIL imm_decode rom_en=%b ir=%h pc=%0d exp 00/a5/1", rom_en, ir, pm_addr); end
    @(negedge clk);
    vectors++; if (rom_en !== 2'b10 || ld_strobe !== 1'b1 || icount !== 8'd0) begin
      errors++; $display("FAIL imm_exec rom_en=%b ld=%b icount=%0d exp 10/1/0", rom_en, ld_strobe, icount); end
    @(negedge clk);
    vectors++; if (rom_en !== 2'b00 || ld_strobe !== 1'b0 || pm_req !== 1'b1 || pm_addr !== 4'd1 || icount !== 8'd1) begin
      errors++; $display("FAIL imm_after rom_en=%b ld=%b req=%b pc=%0d icount=%0d exp 00/0/1/1/1", rom_en, ld_strobe, pm_req, pm_addr, icount); end
  endtask

  task automatic test_alu();
    clear_mem(); mem[0] = 8'h21;
    do_reset(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    vectors++; if (rom_en !== 2'b00 || ir !== 8'h21) begin errors++; $display("FAIL alu_decode rom_en=%b ir=%h exp 00/21", rom_en, ir); end
    @(negedge clk);
    vectors++; if (rom_en !== 2'b01 || ld_strobe !== 1'b0) begin errors++; $display("FAIL alu_exec1 rom_en=%b ld=%b exp 01/0", rom_en, ld_strobe); end
    @(negedge clk);
    vectors++; if (rom_en !== 2'b01 || ld_strobe !== 1'b1 || ir !== 8'h21) begin
      errors++; $display("FAIL alu_exec2 rom_en=%b ld=%b ir=%h exp 01/1/21", rom_en, ld_strobe, ir); end
    @(negedge clk);
    vectors++; if (rom_en !== 2'b00 || pm_req !== 1'b1 || pm_addr !== 4'd1 || icount !== 8'd1) begin
      errors++; $display("FAIL alu_after rom_en=%b req=%b addr=%0d icount=%0d exp 00/1/1/1", rom_en, pm_req, pm_addr, icount); end
  endtask

  task automatic test_fetch_wait();
    int  req_cnt;
    logic stable;
    clear_mem(); mem[0] = 8'hA5;
    do_reset(); start = 1'b1; ack_en = 1'b0;
    req_cnt = 0; stable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); start = 1'b0;
      if (pm_req === 1'b1) req_cnt++;
      if (pm_addr !== 4'd0 || ir !== 8'h00) stable = 1'b0;
      if (c == 3) ack_en = 1'b1;
    end
    vectors++; if (req_cnt !== 4) begin errors++; $display("FAIL wait_req_cycles got=%0d exp=4", req_cnt); end
    vectors++; if (stable !== 1'b1) begin errors++; $display("FAIL wait_stable got=%b exp=1", stable); end
    @(negedge clk);
    vectors++; if (pm_req !== 1'b0 || ir !== 8'hA5 || pm_addr !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL wait_decode req=%b ir=%h pc=%0d busy=%b exp 0/a5/1/1", pm_req, ir, pm_addr, busy); end
  endtask

  task automatic test_halt();
    int cyc;
    clear_mem(); mem[0] = 8'h00; mem[1] = 8'hA1; mem[2] = 8'hFF;
    do_reset(); start = 1'b1;
    cyc = 0;
    while (halt !== 1'b1 && cyc < 30) begin
      @(negedge clk); cyc++; start = 1'b0;
    end
    vectors++; if (cyc !== 8) begin errors++; $display("FAIL halt_cycles got=%0d exp=8", cyc); end
    vectors++; if (icount !== 8'd2 || pm_addr !== 4'd3 || rom_en !== 2'b00) begin
      errors++; $display("FAIL halt_state icount=%0d pc=%0d rom_en=%b exp 2/3/00", icount, pm_addr, rom_en); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = 1'b1; stop = (i == 1);
      @(negedge clk); start = 1'b0; stop = 1'b0;
    end
    @(negedge clk);
    vectors++; if (halt !== 1'b1 || busy !== 1'b0 || pm_req !== 1'b0 || pm_addr !== 4'd3 || icount !== 8'd2) begin
      errors++; $display("FAIL halt_sticky halt=%b busy=%b req=%b pc=%0d icount=%0d exp 1/0/0/3/2", halt, busy, pm_req, pm_addr, icount); end
  endtask

  task automatic test_wrap_stop();
    int cyc;
    clear_mem(); mem[15] = 8'hA0;
    do_reset(); start = 1'b1;
    cyc = 0;
    while (ld_strobe !== 1'b1 && cyc < 60) begin
      @(negedge clk); cyc++; start = 1'b0;
    end
    vectors++; if (cyc !== 33) begin errors++; $display("FAIL wrap_cycles got=%0d exp=33", cyc); end
    vectors++; if (pm_addr !== 4'd0 || rom_en !== 2'b10 || ir !== 8'hA0 || icount !== 8'd15) begin
      errors++; $display("FAIL wrap_exec pc=%0d rom_en=%b ir=%h icount=%0d exp 0/10/a0/15", pm_addr, rom_en, ir, icount); end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    vectors++; if (busy !== 1'b0 || pm_req !== 1'b0 || rom_en !== 2'b00 || icount !== 8'd16) begin
      errors++; $display("FAIL stop_idle busy=%b req=%b rom_en=%b icount=%0d exp 0/0/00/16", busy, pm_req, rom_en, icount); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++; if (pm_req !== 1'b1 || pm_addr !== 4'd0) begin errors++; $display("FAIL resume_fetch req=%b addr=%0d exp 1/0", pm_req, pm_addr); end
  endtask

  task automatic test_rst_mid_exec();
    clear_mem(); mem[0] = 8'h21;
    do_reset(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (rom_en !== 2'b01 || ld_strobe !== 1'b1) begin errors++; $display("FAIL rst6_pre rom_en=%b ld=%b exp 01/1", rom_en, ld_strobe); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    vectors++; if (busy !== 1'b0 || pm_addr !== 4'd0 || icount !== 8'd0 || rom_en !== 2'b00 || ld_strobe !== 1'b0 || ir !== 8'h00) begin
      errors++; $display("FAIL rst6_after busy=%b pc=%0d icount=%0d rom_en=%b ld=%b ir=%h exp 0/0/0/00/0/00",
                         busy, pm_addr, icount, rom_en, ld_strobe, ir); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || pm_req !== 1'b0) begin errors++; $display("FAIL rst6_idle busy=%b req=%b exp 0/0", busy, pm_req); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; ack_en = 1'b1;
    test_reset();
    test_imm();
    test_alu();
    test_fetch_wait();
    test_halt();
    test_wrap_stop();
    test_rst_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
